control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//   SAP-1 microcode sequencer. Steps a 5-state T-counter and decodes (step, opcode, flags)
//   into the one-hot control word that drives PC, MAR, RAM, IR, A/B regs, ALU, flags and OUT.
//   Sits between the instruction register and all datapath blocks.
//   Owns the halt condition and the PC increment, load and halt strobes.
// PARAMETERS
//   OPCODE_WIDTH  4  width of i_opcode (IR upper nibble)
//   NUM_STEPS     5  micro-steps per instruction, T0..T4; STEP_WIDTH = $clog2(NUM_STEPS)
// PORTS
//   mclk         in   1  system clock; all state updates on posedge
//   i_reset      in   1  synchronous, active-high reset
//   mclk_en      in   1  step-advance enable; state holds when low
//   i_opcode     in   4  opcode from IR; valid from T2 onward
//   i_carry      in   1  registered carry flag
//   i_zero       in   1  registered zero flag
//   o_step       out  3  current micro-step, 0..NUM_STEPS-1
//   o_pc_out     out  1  CO: PC drives bus
//   o_pc_inc     out  1  CE: PC increment (PC i_counter_enable)
//   o_pc_load    out  1  J: PC loads bus (PC i_load_enable)
//   o_mar_load   out  1  MI
//   o_ram_out    out  1  RO
//   o_ram_load   out  1  RI
//   o_ir_load    out  1  II
//   o_ir_out     out  1  IO: IR operand nibble drives bus
//   o_a_load     out  1  AI
//   o_a_out      out  1  AO
//   o_b_load     out  1  BI
//   o_alu_out    out  1  EO
//   o_alu_sub    out  1  SU
//   o_flags_load out  1  FI
//   o_out_load   out  1  OI
//   o_halt       out  1  HLT: PC i_halt and clock-enable gating
// BEHAVIOUR
//   State: step register (0..4) and sticky halted bit. Reset sets step=0 and halted=0 on any
//     mclk edge; reset does not depend on mclk_en and aborts any instruction.
//   Reset and T0 outputs: o_pc_out=1, o_mar_load=1, all other outputs 0, o_step=0.
//   Advance: on mclk_en & ~halted, step <= (step==NUM_STEPS-1) ? 0 : step+1.
//     Every instruction takes 5 steps; there is no early termination.
//   Control word: combinational from registered step, i_opcode and flags. There is no
//     output register, so a strobe is valid for the whole step and is captured by the
//     datapath at the mclk_en edge that ends the step.
//   Fetch, identical for every opcode:
//     T0 CO MI
//     T1 RO II CE
//   Execute (T2 / T3 / T4; "-" means no strobes):
//     NOP 0000   -        / -     / -
//     LDA 0001   IO MI    / RO AI / -
//     ADD 0010   IO MI    / RO BI / EO AI FI
//     SUB 0011   IO MI    / RO BI / EO AI SU FI
//     STA 0100   IO MI    / AO RI / -
//     LDI 0101   IO AI    / -     / -
//     JMP 0110   IO J     / -     / -
//     JC  0111   IO J only if i_carry, else - / - / -
//     JZ  1000   IO J only if i_zero,  else - / - / -
//     OUT 1110   AO OI    / -     / -
//     HLT 1111   HLT      / -     / -
//     Opcodes 1001..1101 decode as NOP.
//   Halt:
//     o_halt = halted | (step==2 & opcode==HLT).
//     halted is set at the mclk_en edge that ends T2 of HLT; step stays 2.
//     While halted, every output except o_halt is forced 0, and only reset clears halted.
//   Conditional jumps sample the flags combinationally during T2. Flags change only on FI
//     (T4 of ADD/SUB), so they are stable during T2.
//   Mutual exclusion: at most one bus driver (CO, RO, IO, AO, EO) is asserted in any step.
//     CE and J are never asserted together.
// STRUCTURE
//   sap1_defines.vh: opcode constants (OP_NOP..OP_HLT), step constants (T0..T4) and
//     control-word bit indices, shared with the IR and top-level wiring.
//   One sub-module, microcode_decoder: pure combinational (step, opcode, carry, zero) ->
//     control word. control_sequencer holds the step and halted registers and the halt
//     masking.
// TESTING
//   1. Reset held 2 cycles, then mclk_en=1 with opcode=LDA -> steps 0,1,2,3,4,0.
//      T0: CO MI. T1: RO II CE. T2: IO MI. T3: RO AI. T4: no strobes.
//   2. mclk_en toggled 1-0-0-1 -> step advances only on the enabled edges; outputs are
//      stable while mclk_en is low.
//   3. SUB -> T4 asserts EO AI SU FI. ADD -> T4 asserts EO AI FI with SU=0.
//   4. JC with carry=0, then carry=1 -> T2 J=0 / IO=0, then T2 IO=1 J=1.
//      Same check for JZ using zero.
//   5. HLT -> o_halt=1 during T2, step frozen at 2 for 20 cycles, all other outputs 0.
//      Pulse i_reset -> step=0, o_halt=0, CO MI asserted.
//   6. Reset asserted at T3 of ADD with mclk_en=0 -> step=0 on the next edge and no BI or AI
//      is issued afterwards. Unused opcode 1010 -> no strobes in T2..T4.
//   Every cycle: assert at most one bus driver and never CE & J together.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// ============================================================================
// control_sequencer_pkg
//   Shared opcode, micro-step and control-word definitions for the SAP-1
//   sequencer, instruction register and top-level wiring.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package control_sequencer_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam int NUM_STEPS    = 5;
  localparam int STEP_WIDTH   = $clog2(NUM_STEPS);

  localparam logic [OPCODE_WIDTH-1:0] c_op_nop = 4'b0000;
  localparam logic [OPCODE_WIDTH-1:0] c_op_lda = 4'b0001;
  localparam logic [OPCODE_WIDTH-1:0] c_op_add = 4'b0010;
  localparam logic [OPCODE_WIDTH-1:0] c_op_sub = 4'b0011;
  localparam logic [OPCODE_WIDTH-1:0] c_op_sta = 4'b0100;
  localparam logic [OPCODE_WIDTH-1:0] c_op_ldi = 4'b0101;
  localparam logic [OPCODE_WIDTH-1:0] c_op_jmp = 4'b0110;
  localparam logic [OPCODE_WIDTH-1:0] c_op_jc  = 4'b0111;
  localparam logic [OPCODE_WIDTH-1:0] c_op_jz  = 4'b1000;
  localparam logic [OPCODE_WIDTH-1:0] c_op_out = 4'b1110;
  localparam logic [OPCODE_WIDTH-1:0] c_op_hlt = 4'b1111;

  typedef enum logic [STEP_WIDTH-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  typedef struct packed {
    logic halt;
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_load;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } ctrl_word_t;

endpackage

`default_nettype wire

// File: rtl/control_sequencer_microcode_decoder.sv
// ============================================================================
// microcode_decoder
//   Pure combinational (step, opcode, flags) -> control word lookup.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module microcode_decoder
  import control_sequencer_pkg::*;
(
  input  step_e                   step,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    carry,
  input  logic                    zero,
  output ctrl_word_t              cw
);

  always_comb begin
    cw = '0;
    unique case (step)
      T0: begin
        cw.pc_out   = 1'b1;
        cw.mar_load = 1'b1;
      end
      T1: begin
        cw.ram_out = 1'b1;
        cw.ir_load = 1'b1;
        cw.pc_inc  = 1'b1;
      end
      T2: begin
        case (opcode)
          c_op_lda, c_op_add, c_op_sub, c_op_sta: begin
            cw.ir_out   = 1'b1;
            cw.mar_load = 1'b1;
          end
          c_op_ldi: begin
            cw.ir_out = 1'b1;
            cw.a_load = 1'b1;
          end
          c_op_jmp: begin
            cw.ir_out  = 1'b1;
            cw.pc_load = 1'b1;
          end
          // Flags only move on FI in T4, so sampling them here is glitch-free
          c_op_jc: begin
            cw.ir_out  = carry;
            cw.pc_load = carry;
          end
          c_op_jz: begin
            cw.ir_out  = zero;
            cw.pc_load = zero;
          end
          c_op_out: begin
            cw.a_out    = 1'b1;
            cw.out_load = 1'b1;
          end
          c_op_hlt: cw.halt = 1'b1;
          default:  cw = '0;
        endcase
      end
      T3: begin
        case (opcode)
          c_op_lda: begin
            cw.ram_out = 1'b1;
            cw.a_load  = 1'b1;
          end
          c_op_add, c_op_sub: begin
            cw.ram_out = 1'b1;
            cw.b_load  = 1'b1;
          end
          c_op_sta: begin
            cw.a_out    = 1'b1;
            cw.ram_load = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      T4: begin
        if (opcode == c_op_add || opcode == c_op_sub) begin
          cw.alu_out    = 1'b1;
          cw.a_load     = 1'b1;
          cw.flags_load = 1'b1;
          cw.alu_sub    = (opcode == c_op_sub);
        end
      end
      default: cw = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer
//   SAP-1 T-state counter with sticky halt; drives the datapath control word.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                    mclk,
  input  logic                    i_reset,
  input  logic                    mclk_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_carry,
  input  logic                    i_zero,
  output logic [STEP_WIDTH-1:0]   o_step,
  output logic                    o_pc_out,
  output logic                    o_pc_inc,
  output logic                    o_pc_load,
  output logic                    o_mar_load,
  output logic                    o_ram_out,
  output logic                    o_ram_load,
  output logic                    o_ir_load,
  output logic                    o_ir_out,
  output logic                    o_a_load,
  output logic                    o_a_out,
  output logic                    o_b_load,
  output logic                    o_alu_out,
  output logic                    o_alu_sub,
  output logic                    o_flags_load,
  output logic                    o_out_load,
  output logic                    o_halt
);

  step_e      r_step;
  step_e      w_step_nxt;
  logic       r_halted;
  logic       w_halted_nxt;
  ctrl_word_t w_cw;
  ctrl_word_t w_cw_masked;

  microcode_decoder u_decoder (
    .step   (r_step),
    .opcode (i_opcode),
    .carry  (i_carry),
    .zero   (i_zero),
    .cw     (w_cw)
  );

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= w_step_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // HLT freezes the counter at T2 instead of advancing out of it
  always_comb begin
    w_step_nxt   = r_step;
    w_halted_nxt = r_halted;
    if (mclk_en && !r_halted) begin
      if (w_cw.halt) begin
        w_halted_nxt = 1'b1;
      end else if (r_step == step_e'(NUM_STEPS - 1)) begin
        w_step_nxt = T0;
      end else begin
        w_step_nxt = step_e'(r_step + 1'b1);
      end
    end
  end

  always_comb begin
    w_cw_masked = r_halted ? '0 : w_cw;
  end

  assign o_step       = r_step;
  assign o_pc_out     = w_cw_masked.pc_out;
  assign o_pc_inc     = w_cw_masked.pc_inc;
  assign o_pc_load    = w_cw_masked.pc_load;
  assign o_mar_load   = w_cw_masked.mar_load;
  assign o_ram_out    = w_cw_masked.ram_out;
  assign o_ram_load   = w_cw_masked.ram_load;
  assign o_ir_load    = w_cw_masked.ir_load;
  assign o_ir_out     = w_cw_masked.ir_out;
  assign o_a_load     = w_cw_masked.a_load;
  assign o_a_out      = w_cw_masked.a_out;
  assign o_b_load     = w_cw_masked.b_load;
  assign o_alu_out    = w_cw_masked.alu_out;
  assign o_alu_sub    = w_cw_masked.alu_sub;
  assign o_flags_load = w_cw_masked.flags_load;
  assign o_out_load   = w_cw_masked.out_load;
  assign o_halt       = r_halted | w_cw.halt;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// tb_control_sequencer
//   Directed checks of the SAP-1 sequencer against hand-computed control words.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  localparam logic [15:0] c_hlt = 16'h8000;
  localparam logic [15:0] c_co  = 16'h4000;
  localparam logic [15:0] c_ce  = 16'h2000;
  localparam logic [15:0] c_j   = 16'h1000;
  localparam logic [15:0] c_mi  = 16'h0800;
  localparam logic [15:0] c_ro  = 16'h0400;
  localparam logic [15:0] c_ri  = 16'h0200;
  localparam logic [15:0] c_ii  = 16'h0100;
  localparam logic [15:0] c_io  = 16'h0080;
  localparam logic [15:0] c_ai  = 16'h0040;
  localparam logic [15:0] c_ao  = 16'h0020;
  localparam logic [15:0] c_bi  = 16'h0010;
  localparam logic [15:0] c_eo  = 16'h0008;
  localparam logic [15:0] c_su  = 16'h0004;
  localparam logic [15:0] c_fi  = 16'h0002;
  localparam logic [15:0] c_oi  = 16'h0001;
  localparam logic [15:0] c_fetch0 = c_co | c_mi;
  localparam logic [15:0] c_fetch1 = c_ro | c_ii | c_ce;

  logic       mclk = 1'b0;
  logic       i_reset = 1'b1;
  logic       mclk_en = 1'b0;
  logic [3:0] i_opcode = 4'h0;
  logic       i_carry = 1'b0;
  logic       i_zero = 1'b0;
  logic [2:0] o_step;
  logic o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_load;
  logic o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_out;
  logic o_alu_sub, o_flags_load, o_out_load, o_halt;

  int total = 0;
  int bad   = 0;

  control_sequencer dut (
    .mclk         (mclk),
    .i_reset      (i_reset),
    .mclk_en      (mclk_en),
    .i_opcode     (i_opcode),
    .i_carry      (i_carry),
    .i_zero       (i_zero),
    .o_step       (o_step),
    .o_pc_out     (o_pc_out),
    .o_pc_inc     (o_pc_inc),
    .o_pc_load    (o_pc_load),
    .o_mar_load   (o_mar_load),
    .o_ram_out    (o_ram_out),
    .o_ram_load   (o_ram_load),
    .o_ir_load    (o_ir_load),
    .o_ir_out     (o_ir_out),
    .o_a_load     (o_a_load),
    .o_a_out      (o_a_out),
    .o_b_load     (o_b_load),
    .o_alu_out    (o_alu_out),
    .o_alu_sub    (o_alu_sub),
    .o_flags_load (o_flags_load),
    .o_out_load   (o_out_load),
    .o_halt       (o_halt)
  );

  always #5 mclk = ~mclk;

  wire [15:0] w_word = {o_halt, o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out,
                        o_ram_load, o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load,
                        o_alu_out, o_alu_sub, o_flags_load, o_out_load};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #2;
  endtask

  task automatic expect_state(input string tag, input logic [2:0] step, input logic [15:0] word);
    #1;
    chk({tag, "_step"}, {29'd0, o_step}, {29'd0, step});
    chk({tag, "_word"}, {16'd0, w_word}, {16'd0, word});
  endtask

  // Runs one full instruction from T0 with mclk_en high, ending back at T0
  task automatic run_instr(input string tag, input logic [3:0] op, input logic c, input logic z,
                           input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
    i_opcode = op;
    i_carry  = c;
    i_zero   = z;
    mclk_en  = 1'b1;
    expect_state({tag, "_t0"}, 3'd0, c_fetch0);
    tick(); expect_state({tag, "_t1"}, 3'd1, c_fetch1);
    tick(); expect_state({tag, "_t2"}, 3'd2, w2);
    tick(); expect_state({tag, "_t3"}, 3'd3, w3);
    tick(); expect_state({tag, "_t4"}, 3'd4, w4);
    tick();
  endtask

  // Continuous structural checks sampled away from the active edge
  always @(negedge mclk) begin
    if (!i_reset) begin
      chk("bus_excl", {31'd0, (32'(o_pc_out) + 32'(o_ram_out) + 32'(o_ir_out)
                               + 32'(o_a_out) + 32'(o_alu_out)) <= 32'd1}, 32'd1);
      chk("ce_j_excl", {31'd0, o_pc_inc & o_pc_load}, 32'd0);
    end
  end

  initial begin
    tick(); tick();
    expect_state("reset", 3'd0, c_fetch0);
    i_reset = 1'b0;

    run_instr("lda", 4'b0001, 1'b0, 1'b0, c_io | c_mi, c_ro | c_ai, 16'h0000);
    expect_state("lda_wrap", 3'd0, c_fetch0);

    // mclk_en pattern 1-0-0-1
    i_opcode = 4'b0000;
    mclk_en  = 1'b1; tick(); expect_state("en1", 3'd1, c_fetch1);
    mclk_en  = 1'b0; tick(); expect_state("en0a", 3'd1, c_fetch1);
    tick(); expect_state("en0b", 3'd1, c_fetch1);
    mclk_en  = 1'b1; tick(); expect_state("en1b", 3'd2, 16'h0000);
    tick(); tick(); tick();
    expect_state("nop_wrap", 3'd0, c_fetch0);

    run_instr("sub", 4'b0011, 1'b0, 1'b0, c_io | c_mi, c_ro | c_bi, c_eo | c_ai | c_su | c_fi);
    run_instr("add", 4'b0010, 1'b0, 1'b0, c_io | c_mi, c_ro | c_bi, c_eo | c_ai | c_fi);
    run_instr("jc0", 4'b0111, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    run_instr("jc1", 4'b0111, 1'b1, 1'b0, c_io | c_j, 16'h0000, 16'h0000);
    run_instr("jz0", 4'b1000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    run_instr("jz1", 4'b1000, 1'b0, 1'b1, c_io | c_j, 16'h0000, 16'h0000);
    run_instr("sta", 4'b0100, 1'b0, 1'b0, c_io | c_mi, c_ao | c_ri, 16'h0000);
    run_instr("ldi", 4'b0101, 1'b0, 1'b0, c_io | c_ai, 16'h0000, 16'h0000);
    run_instr("jmp", 4'b0110, 1'b0, 1'b0, c_io | c_j, 16'h0000, 16'h0000);
    run_instr("out", 4'b1110, 1'b0, 1'b0, c_ao | c_oi, 16'h0000, 16'h0000);
    i_carry = 1'b0;
    i_zero  = 1'b0;

    // HLT: freeze at T2
    i_opcode = 4'b1111;
    expect_state("hlt_t0", 3'd0, c_fetch0);
    tick(); expect_state("hlt_t1", 3'd1, c_fetch1);
    tick(); expect_state("hlt_t2", 3'd2, c_hlt);
    for (int i = 0; i < 20; i++) begin
      tick(); expect_state("hlt_hold", 3'd2, c_hlt);
    end
    i_opcode = 4'b0001;
    #1; chk("hlt_sticky", {16'd0, w_word}, {16'd0, c_hlt});
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    expect_state("hlt_reset", 3'd0, c_fetch0);

    // Reset aborting ADD at T3 while mclk_en is low
    i_opcode = 4'b0010;
    tick(); tick(); tick();
    expect_state("abort_t3", 3'd3, c_ro | c_bi);
    mclk_en = 1'b0;
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    expect_state("abort_rst", 3'd0, c_fetch0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("abort_idle", 3'd0, c_fetch0);
    end

    run_instr("op1010", 4'b1010, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    expect_state("final", 3'd0, c_fetch0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
